// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-FSM state encoding, instruction opcodes and
// ALU function-select codes, used by both the control unit and the datapath.
`default_nettype none

package cpu_pkg;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,
    S_ADDR1  = 5'd5,
    S_ADDR2  = 5'd6,
    S_LDAC3  = 5'd7,
    S_LDAC4  = 5'd8,
    S_STAC3  = 5'd9,
    S_STAC4  = 5'd10,
    S_MVAC1  = 5'd11,
    S_MOVR1  = 5'd12,
    S_JMP1   = 5'd13,
    S_JMP2   = 5'd14,
    S_SKIP1  = 5'd15,
    S_ALUR1  = 5'd16,
    S_ALUA1  = 5'd17
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_INAC = 4'hA;
  localparam logic [3:0] OP_CLAC = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  // ALUS[7:1], bit 6 of the vector is ALUS7
  localparam logic [6:0] ALUS_NONE = 7'b0000000;
  localparam logic [6:0] ALUS_PASS = 7'b0000010;
  localparam logic [6:0] ALUS_ADD  = 7'b0000011;
  localparam logic [6:0] ALUS_SUB  = 7'b0001101;
  localparam logic [6:0] ALUS_INAC = 7'b0001001;
  localparam logic [6:0] ALUS_CLAC = 7'b0000000;
  localparam logic [6:0] ALUS_AND  = 7'b1000000;
  localparam logic [6:0] ALUS_OR   = 7'b1010000;
  localparam logic [6:0] ALUS_XOR  = 7'b1100000;
  localparam logic [6:0] ALUS_NOT  = 7'b1110000;

  function automatic logic [6:0] alu_code(input logic [3:0] op);
    logic [6:0] code;
    code = ALUS_NONE;
    case (op)
      OP_ADD:  code = ALUS_ADD;
      OP_SUB:  code = ALUS_SUB;
      OP_INAC: code = ALUS_INAC;
      OP_CLAC: code = ALUS_CLAC;
      OP_AND:  code = ALUS_AND;
      OP_OR:   code = ALUS_OR;
      OP_XOR:  code = ALUS_XOR;
      OP_NOT:  code = ALUS_NOT;
      default: code = ALUS_NONE;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: instruction/flag inputs and the
// register, bus, ALU and memory strobes.
`default_nettype none

interface control_unit_if;
  logic [3:0] opcode;
  logic       z;
  logic       pc_bus;
  logic       pc_load;
  logic       pc_inc;
  logic       ar_load;
  logic       dr_load;
  logic       dr_bus;
  logic       ir_load;
  logic       r_load;
  logic       r_bus;
  logic       ac_load;
  logic       ac_bus;
  logic       z_load;
  logic [7:1] alus;
  logic       mem_read;
  logic       mem_write;

  // Control unit side: consumes opcode/flag, drives every strobe
  modport master (
    input  opcode, z,
    output pc_bus, pc_load, pc_inc, ar_load, dr_load, dr_bus, ir_load,
           r_load, r_bus, ac_load, ac_bus, z_load, alus, mem_read, mem_write
  );

  modport slave (
    output opcode, z,
    input  pc_bus, pc_load, pc_inc, ar_load, dr_load, dr_bus, ir_load,
           r_load, r_bus, ac_load, ac_bus, z_load, alus, mem_read, mem_write
  );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// Moore control FSM for the accumulator CPU: fetch, decode and execute
// sequencing; strobes depend only on the state and the op latched at DECODE.
`default_nettype none

module control_unit
  import cpu_pkg::*;
(
  input  wire logic      CLK,
  input  wire logic      RESET,
  control_unit_if.master bus
);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        // Later opcode changes must not alter the rest of this instruction
        op_d = bus.opcode;
        case (bus.opcode)
          OP_NOP:                              state_d = S_FETCH1;
          OP_LDAC, OP_STAC:                    state_d = S_ADDR1;
          OP_MVAC:                             state_d = S_MVAC1;
          OP_MOVR:                             state_d = S_MOVR1;
          OP_JUMP:                             state_d = S_JMP1;
          OP_JMPZ:                             state_d = bus.z ? S_JMP1 : S_SKIP1;
          OP_JPNZ:                             state_d = bus.z ? S_SKIP1 : S_JMP1;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_ALUR1;
          default:                             state_d = S_ALUA1;
        endcase
      end
      S_ADDR1:  state_d = S_ADDR2;
      S_ADDR2:  state_d = (op_q == OP_STAC) ? S_STAC3 : S_LDAC3;
      S_LDAC3:  state_d = S_LDAC4;
      S_STAC3:  state_d = S_STAC4;
      S_JMP1:   state_d = S_JMP2;
      default:  state_d = S_FETCH1;
    endcase
  end

  always_comb begin
    bus.pc_bus    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.ar_load   = 1'b0;
    bus.dr_load   = 1'b0;
    bus.dr_bus    = 1'b0;
    bus.ir_load   = 1'b0;
    bus.r_load    = 1'b0;
    bus.r_bus     = 1'b0;
    bus.ac_load   = 1'b0;
    bus.ac_bus    = 1'b0;
    bus.z_load    = 1'b0;
    bus.alus      = ALUS_NONE;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      S_FETCH1: begin
        bus.pc_bus  = 1'b1;
        bus.ar_load = 1'b1;
      end
      S_FETCH2, S_ADDR1: begin
        bus.mem_read = 1'b1;
        bus.dr_load  = 1'b1;
        bus.pc_inc   = 1'b1;
      end
      S_FETCH3: begin
        bus.ir_load = 1'b1;
        bus.pc_bus  = 1'b1;
        bus.ar_load = 1'b1;
      end
      S_ADDR2: begin
        bus.dr_bus  = 1'b1;
        bus.ar_load = 1'b1;
      end
      S_LDAC3, S_JMP1: begin
        bus.mem_read = 1'b1;
        bus.dr_load  = 1'b1;
      end
      S_LDAC4: begin
        bus.dr_bus  = 1'b1;
        bus.ac_load = 1'b1;
        bus.z_load  = 1'b1;
        bus.alus    = ALUS_PASS;
      end
      S_STAC3: begin
        bus.ac_bus  = 1'b1;
        bus.dr_load = 1'b1;
      end
      S_STAC4:  bus.mem_write = 1'b1;
      S_MVAC1: begin
        bus.ac_bus = 1'b1;
        bus.r_load = 1'b1;
      end
      S_MOVR1: begin
        bus.r_bus   = 1'b1;
        bus.ac_load = 1'b1;
        bus.z_load  = 1'b1;
        bus.alus    = ALUS_PASS;
      end
      S_JMP2: begin
        bus.dr_bus  = 1'b1;
        bus.pc_load = 1'b1;
      end
      S_SKIP1:  bus.pc_inc = 1'b1;
      S_ALUR1: begin
        bus.r_bus   = 1'b1;
        bus.ac_load = 1'b1;
        bus.z_load  = 1'b1;
        bus.alus    = alu_code(op_q);
      end
      S_ALUA1: begin
        bus.ac_load = 1'b1;
        bus.z_load  = 1'b1;
        bus.alus    = alu_code(op_q);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
